aha_prog_clock_divider: RTL

- Parametrised, runtime-programmable successor to the fixed power-of-two platform clock divider.
- Produces NUM_CH independent register-generated divided clocks from CLK_IN. Any integer ratio from 2 to 2^DIV_W-1 is supported.
- Each channel has a matching one-cycle clock-enable pulse, glitch-free start/stop, and ratio changes applied only at period boundaries under a req/ack handshake.
- Sits in the platform controller, feeding clock gates and enable-qualified logic in the CLK_IN domain.

---
 rtl/aha_prog_clock_divider.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/aha_prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : aha_prog_clock_divider
// Brief    : NUM_CH runtime-programmable register-generated clock dividers with
//            per-channel enable pulses, glitch-free start/stop and req/ack
//            ratio updates applied at period boundaries.
//            Optional phase alignment: define AHA_CLKDIV_PHASE_ALIGN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aha_prog_clock_divider #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                    CLK_IN,
    input  logic                    RESETn,
    input  logic [NUM_CH-1:0]       CH_EN,
    input  logic [NUM_CH*DIV_W-1:0] DIV_RATIO,
    input  logic                    DIV_REQ,
    output logic                    DIV_ACK,
    output logic                    DIV_BUSY,
`ifdef AHA_CLKDIV_PHASE_ALIGN_EN
    input  logic                    ALIGN_REQ,
    output logic                    ALIGN_DONE,
`endif
    output logic [NUM_CH-1:0]       CLK_OUT,
    output logic [NUM_CH-1:0]       CLK_OUT_EN
);

    localparam int               DEF_CLAMPED = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
    localparam logic [DIV_W-1:0] DEF_D       = DEF_CLAMPED[DIV_W-1:0];
    localparam logic [DIV_W-1:0] ONE         = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] MIN_D       = {{(DIV_W-2){1'b0}}, 2'b10};

    typedef enum logic {
        CH_STOPPED = 1'b0,
        CH_RUNNING = 1'b1
    } ch_state_t;

    typedef enum logic [1:0] {
        UPD_IDLE    = 2'd0,
        UPD_PENDING = 2'd1,
        UPD_ACK     = 2'd2
    } upd_state_t;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v < MIN_D) ? MIN_D : v;
    endfunction

    upd_state_t        upd_state;
    logic              capture;
    logic [NUM_CH-1:0] pend_vec;
    logic [NUM_CH-1:0] ready_vec;
    logic [NUM_CH-1:0] member;
    logic              align_act;
    logic              all_ready;

    assign capture   = (upd_state == UPD_IDLE) && DIV_REQ;
    assign all_ready = &ready_vec;

    // Ratio update handshake; DIV_ACK and DIV_BUSY are registered outputs.
    always_ff @(posedge CLK_IN or negedge RESETn) begin
        if (!RESETn) begin
            upd_state <= UPD_IDLE;
            DIV_ACK   <= 1'b0;
            DIV_BUSY  <= 1'b0;
        end else begin
            case (upd_state)
                UPD_IDLE: begin
                    DIV_ACK <= 1'b0;
                    if (DIV_REQ) begin
                        upd_state <= UPD_PENDING;
                        DIV_BUSY  <= 1'b1;
                    end
                end
                UPD_PENDING: begin
                    if (pend_vec == '0) begin
                        upd_state <= UPD_ACK;
                        DIV_ACK   <= 1'b1;
                    end
                end
                UPD_ACK: begin
                    upd_state <= UPD_IDLE;
                    DIV_ACK   <= 1'b0;
                    DIV_BUSY  <= 1'b0;
                end
                default: begin
                    upd_state <= UPD_IDLE;
                    DIV_ACK   <= 1'b0;
                    DIV_BUSY  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AHA_CLKDIV_PHASE_ALIGN_EN
    logic [NUM_CH-1:0] run_vec;

    // Membership is frozen at arm time so channels stopped then never gate release.
    always_ff @(posedge CLK_IN or negedge RESETn) begin
        if (!RESETn) begin
            align_act  <= 1'b0;
            member     <= '0;
            ALIGN_DONE <= 1'b0;
        end else begin
            ALIGN_DONE <= 1'b0;
            if (align_act) begin
                if (all_ready) begin
                    align_act  <= 1'b0;
                    ALIGN_DONE <= 1'b1;
                end
            end else if (ALIGN_REQ && (upd_state == UPD_IDLE) && !DIV_REQ) begin
                align_act <= 1'b1;
                member    <= run_vec;
            end
        end
    end
`else
    assign align_act = 1'b0;
    assign member    = '0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t        state;
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] shadow_q;
        logic [DIV_W-1:0] div_eff;
        logic [DIV_W-1:0] cnt_inc;
        logic [DIV_W-1:0] field;
        logic             pend_q;
        logic             clk_q;
        logic             running;
        logic             tc;
        logic             hold;

        assign field   = DIV_RATIO[i*DIV_W +: DIV_W];
        assign running = (state == CH_RUNNING);
        assign tc      = running && (cnt_q == (div_q - ONE));
        assign cnt_inc = cnt_q + ONE;
        assign div_eff = pend_q ? shadow_q : div_q;

        // A channel about to stop is not ready; once stopped it no longer blocks release.
        assign ready_vec[i] = !member[i] || !running || (tc && CH_EN[i]);
        assign hold         = align_act && member[i] && tc && CH_EN[i] && !all_ready;

        always_ff @(posedge CLK_IN or negedge RESETn) begin
            if (!RESETn) begin
                state    <= CH_STOPPED;
                cnt_q    <= '0;
                div_q    <= DEF_D;
                shadow_q <= DEF_D;
                pend_q   <= 1'b0;
                clk_q    <= 1'b0;
            end else begin
                case (state)
                    CH_STOPPED: begin
                        clk_q <= 1'b0;
                        if (pend_q) begin
                            div_q  <= shadow_q;
                            pend_q <= 1'b0;
                        end
                        if (CH_EN[i]) begin
                            state <= CH_RUNNING;
                            cnt_q <= div_eff - ONE;
                        end
                    end
                    CH_RUNNING: begin
                        if (!tc) begin
                            cnt_q <= cnt_inc;
                            clk_q <= (cnt_inc < (div_q >> 1));
                        end else if (!hold) begin
                            // Period boundary: new ratio, restart or stop all land here.
                            if (pend_q) begin
                                div_q  <= shadow_q;
                                pend_q <= 1'b0;
                            end
                            cnt_q <= '0;
                            clk_q <= CH_EN[i];
                            if (!CH_EN[i]) begin
                                state <= CH_STOPPED;
                            end
                        end
                    end
                    default: state <= CH_STOPPED;
                endcase
                if (capture) begin
                    shadow_q <= clamp_div(field);
                    pend_q   <= 1'b1;
                end
            end
        end

        assign CLK_OUT[i]    = clk_q;
        assign CLK_OUT_EN[i] = tc && CH_EN[i] && !hold;
        assign pend_vec[i]   = pend_q;
`ifdef AHA_CLKDIV_PHASE_ALIGN_EN
        assign run_vec[i]    = running;
`endif
    end

endmodule
`default_nettype wire
